// File: rtl/dma_pkg.sv
// Shared types, widths and the burst write-mask helper for the DMA controller.
package dma_pkg;

    localparam int unsigned WORD_SIZE   = 16;
    localparam int unsigned BURST_WORDS = 4;
    localparam int unsigned LINE_WIDTH  = WORD_SIZE * BURST_WORDS;

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StWrite,
        StNext,
        StDone
    } dma_state_e;

    // Enable one bit per word still owed, capped at a full line.
    function automatic logic [BURST_WORDS-1:0] burst_mask(input logic [WORD_SIZE-1:0] remaining);
        logic [BURST_WORDS-1:0] m;
        m = '0;
        for (int i = 0; i < BURST_WORDS; i++) begin
            if (remaining > WORD_SIZE'(i)) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/dma_controller_if.sv
// CPU handshake, device-buffer and memory-write signals of the DMA controller.
interface dma_controller_if;
    import dma_pkg::*;

    logic                   begin_dma;
    logic [WORD_SIZE-1:0]   target_address;
    logic [WORD_SIZE-1:0]   length;
    logic                   bg;
    logic                   br;
    logic [LINE_WIDTH-1:0]  dev_data;
    logic [WORD_SIZE-1:0]   dev_index;
    logic                   mem_ack;
    logic                   dma_write;
    logic [WORD_SIZE-1:0]   dma_address;
    logic [LINE_WIDTH-1:0]  dma_write_data;
    logic [BURST_WORDS-1:0] dma_mask;
    logic                   dma_done;
    logic                   busy;

    modport master (
        input  begin_dma, target_address, length, bg, dev_data, mem_ack,
        output br, dev_index, dma_write, dma_address, dma_write_data, dma_mask, dma_done, busy
    );

    modport slave (
        output begin_dma, target_address, length, bg, dev_data, mem_ack,
        input  br, dev_index, dma_write, dma_address, dma_write_data, dma_mask, dma_done, busy
    );

endinterface

// File: rtl/dma_burst_counter.sv
// Transfer bookkeeping: destination address, words remaining and device line index.
module dma_burst_counter
    import dma_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   load_i,
    input  logic                   step_i,
    input  logic [WORD_SIZE-1:0]   addr_i,
    input  logic [WORD_SIZE-1:0]   len_i,
    output logic [WORD_SIZE-1:0]   addr_o,
    output logic [WORD_SIZE-1:0]   dev_index_o,
    output logic [BURST_WORDS-1:0] mask_o,
    output logic                   last_burst_o
);

    logic [WORD_SIZE-1:0] addr_q, addr_d;
    logic [WORD_SIZE-1:0] rem_q, rem_d;
    logic [WORD_SIZE-1:0] idx_q, idx_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q <= '0;
            rem_q  <= '0;
            idx_q  <= '0;
        end else begin
            addr_q <= addr_d;
            rem_q  <= rem_d;
            idx_q  <= idx_d;
        end
    end

    always_comb begin
        addr_d = addr_q;
        rem_d  = rem_q;
        idx_d  = idx_q;
        if (load_i) begin
            addr_d = addr_i;
            rem_d  = len_i;
            idx_d  = '0;
        end else if (step_i) begin
            // Address wraps modulo 2^WORD_SIZE by plain truncation.
            addr_d = addr_q + WORD_SIZE'(BURST_WORDS);
            rem_d  = (rem_q >= WORD_SIZE'(BURST_WORDS)) ? rem_q - WORD_SIZE'(BURST_WORDS) : '0;
            idx_d  = idx_q + WORD_SIZE'(1);
        end
    end

    assign addr_o       = addr_q;
    assign dev_index_o  = idx_q;
    assign mask_o       = burst_mask(rem_q);
    // High once the burst just stepped over was the final one.
    assign last_burst_o = (rem_q == '0);

endmodule

// File: rtl/dma_controller.sv
// Bus-master DMA engine copying device-buffer words into memory in 4-word bursts.
// Define DMA_CYCLE_STEAL_EN to drop br for one cycle between bursts (cycle stealing).
module dma_controller
    import dma_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    dma_controller_if.master dma_bus
);

`ifdef DMA_CYCLE_STEAL_EN
    localparam bit CycleSteal = 1'b1;
`else
    localparam bit CycleSteal = 1'b0;
`endif

    dma_state_e             state_q, state_d;
    logic                   load, step, capture;
    logic                   last_burst;
    logic [WORD_SIZE-1:0]   addr, dev_index;
    logic [BURST_WORDS-1:0] mask;
    logic [LINE_WIDTH-1:0]  data_q, data_d;
    logic                   done_q, done_d;

    dma_burst_counter u_counter (
        .clk          (clk),
        .reset_n      (reset_n),
        .load_i       (load),
        .step_i       (step),
        .addr_i       (dma_bus.target_address),
        .len_i        (dma_bus.length),
        .addr_o       (addr),
        .dev_index_o  (dev_index),
        .mask_o       (mask),
        .last_burst_o (last_burst)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            data_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        capture = 1'b0;
        case (state_q)
            StIdle: begin
                if (dma_bus.begin_dma) begin
                    load    = 1'b1;
                    state_d = (dma_bus.length == '0) ? StDone : StReq;
                end
            end
            StReq: begin
                if (dma_bus.bg) begin
                    capture = 1'b1;
                    state_d = StWrite;
                end
            end
            StWrite: begin
                // An ack in the same cycle as a grant drop still completes the burst.
                if (dma_bus.mem_ack) begin
                    step    = 1'b1;
                    state_d = StNext;
                end else if (!dma_bus.bg) begin
                    state_d = StReq;
                end
            end
            StNext: begin
                if (last_burst) begin
                    state_d = StDone;
                end else if (CycleSteal) begin
                    state_d = StReq;
                end else begin
                    capture = 1'b1;
                    state_d = StWrite;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
        data_d = capture ? dma_bus.dev_data : data_q;
        done_d = (state_q == StDone);
    end

    always_comb begin
        dma_bus.br        = 1'b0;
        dma_bus.dma_write = 1'b0;
        dma_bus.dma_mask  = '0;
        case (state_q)
            StReq:   dma_bus.br = 1'b1;
            StWrite: begin
                dma_bus.br        = 1'b1;
                dma_bus.dma_write = 1'b1;
                dma_bus.dma_mask  = mask;
            end
            StNext:  dma_bus.br = !last_burst && !CycleSteal;
            default: ;
        endcase
        dma_bus.busy           = (state_q != StIdle);
        dma_bus.dma_done       = done_q;
        dma_bus.dma_address    = addr;
        dma_bus.dev_index      = dev_index;
        dma_bus.dma_write_data = data_q;
    end

endmodule

// File: tb/tb_dma_controller.sv
// Randomised scoreboard bench for dma_controller with a bus/memory responder model.
module tb_dma_controller;
    import dma_pkg::*;

    typedef struct {
        logic [15:0] addr;
        logic [3:0]  mask;
        logic [63:0] data;
        logic [15:0] idx;
    } exp_t;

    logic clk;
    logic reset_n;
    dma_controller_if dif ();

    dma_controller dut (
        .clk     (clk),
        .reset_n (reset_n),
        .dma_bus (dif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [63:0] dev_buf [8];
    assign dif.dev_data = dev_buf[dif.dev_index[2:0]];

    exp_t exp_q[$];
    int   n_checks, n_fail;
    int   pending_done, done_cnt, ack_cnt, write_starts, br_falls;
    int   resp_acks, drop_at_ack;
    bit   rand_lat, rand_drop;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: burst k writes line k to a+4k with one enable per word still owed.
    task automatic push_expect(input logic [15:0] a, input logic [15:0] len);
        for (int k = 0; k * 4 < int'(len); k++) begin
            exp_t e;
            int   rem;
            rem    = int'(len) - 4 * k;
            e.addr = a + 16'(4 * k);
            e.mask = (rem >= 4) ? 4'hF : 4'((1 << rem) - 1);
            e.data = dev_buf[k % 8];
            e.idx  = 16'(k);
            exp_q.push_back(e);
        end
    endtask

    task automatic fill_buf();
        for (int i = 0; i < 8; i++) dev_buf[i] = {$urandom, $urandom};
    endtask

    task automatic pulse_begin(input logic [15:0] a, input logic [15:0] len);
        @(posedge clk); #1;
        dif.begin_dma      = 1'b1;
        dif.target_address = a;
        dif.length         = len;
        @(posedge clk); #1;
        dif.begin_dma      = 1'b0;
        dif.target_address = 16'($urandom);
        dif.length         = 16'($urandom);
    endtask

    task automatic run_xfer(input logic [15:0] a, input logic [15:0] len, input bit inject);
        int nb, falls0, done0, exp_falls;
        bit got;
        nb = (int'(len) + 3) / 4;
`ifdef DMA_CYCLE_STEAL_EN
        exp_falls = nb;
`else
        exp_falls = (nb == 0) ? 0 : 1;
`endif
        push_expect(a, len);
        pending_done++;
        falls0 = br_falls;
        done0  = done_cnt;
        pulse_begin(a, len);
        @(negedge clk);
        chk("busy_after_begin", dif.busy, 1);
        chk("br_after_begin", dif.br, len != 0);
        if (inject && len != 0) begin
            @(posedge clk); #1;
            dif.begin_dma      = 1'b1;
            dif.target_address = 16'($urandom);
            dif.length         = 16'($urandom_range(1, 30));
            @(posedge clk); #1;
            dif.begin_dma      = 1'b0;
        end
        got = 1'b0;
        for (int i = 0; i < 2000 && !got; i++) begin
            @(negedge clk); #1;
            if (done_cnt != done0) got = 1'b1;
        end
        chk("done_seen", got, 1);
        chk("br_falls", br_falls - falls0, exp_falls);
        chk("bursts_outstanding", exp_q.size(), 0);
        if (!got) begin
            exp_q.delete();
            pending_done = 0;
        end
        @(posedge clk); #1;
    endtask

    // Bus/memory responder: bg follows br one cycle late; ack after a latency; optional drops.
    initial begin
        int   wcnt, hold, lat;
        logic br_prev;
        dif.bg = 1'b0; dif.mem_ack = 1'b0;
        wcnt = 0; hold = 0; lat = 2; br_prev = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (!reset_n) begin
                wcnt = 0; hold = 0; br_prev = 1'b0;
                dif.bg = 1'b0; dif.mem_ack = 1'b0;
            end else begin
                if (dif.dma_write) wcnt++; else wcnt = 0;
                if (wcnt == 1) begin
                    lat = rand_lat ? int'($urandom_range(0, 3)) : 2;
                    if ((drop_at_ack >= 0 && resp_acks == drop_at_ack) ||
                        (rand_drop && $urandom_range(0, 5) == 0)) begin
                        hold = 2;
                        if (drop_at_ack >= 0 && resp_acks == drop_at_ack) drop_at_ack = -1;
                    end
                end
                dif.mem_ack = dif.dma_write && (wcnt == lat + 1);
                if (dif.mem_ack) resp_acks++;
                if (hold > 0) begin
                    dif.bg = 1'b0;
                    hold--;
                end else begin
                    dif.bg = br_prev;
                end
                br_prev = dif.br;
            end
        end
    end

    // Monitor: scoreboard pops on each accepted write; protocol checks each cycle.
    logic        prev_write, prev_br, prev_ack, prev_bg;
    logic [15:0] prev_addr;
    logic [63:0] prev_data;
    logic [3:0]  prev_mask;
    exp_t        mon_e;

    always @(negedge clk) begin
        if (!reset_n) begin
            prev_write = 1'b0; prev_br = 1'b0; prev_ack = 1'b0; prev_bg = 1'b0;
        end else begin
            if (dif.dma_write && dif.mem_ack) begin
                ack_cnt++;
                chk("write_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    chk("dma_address", dif.dma_address, mon_e.addr);
                    chk("dma_mask", dif.dma_mask, mon_e.mask);
                    chk("dma_write_data", dif.dma_write_data, mon_e.data);
                    chk("dev_index", dif.dev_index, mon_e.idx);
                end
            end
            if (dif.dma_write && !prev_write) write_starts++;
            if (dif.dma_write && prev_write) begin
                chk("held_write_had_grant", prev_bg, 1);
                chk("held_address", dif.dma_address, prev_addr);
                chk("held_data", dif.dma_write_data, prev_data);
                chk("held_mask", dif.dma_mask, prev_mask);
            end
            if (dif.dma_done) begin
                done_cnt++;
                chk("busy_at_done", dif.busy, 0);
                chk("done_expected", pending_done > 0, 1);
                if (pending_done > 0) pending_done--;
            end
            if (prev_br && !dif.br) br_falls++;
            prev_write = dif.dma_write;
            prev_br    = dif.br;
            prev_ack   = dif.mem_ack;
            prev_bg    = dif.bg;
            prev_addr  = dif.dma_address;
            prev_data  = dif.dma_write_data;
            prev_mask  = dif.dma_mask;
        end
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_br"}, dif.br, 0);
        chk({tag, "_dma_write"}, dif.dma_write, 0);
        chk({tag, "_dma_done"}, dif.dma_done, 0);
        chk({tag, "_busy"}, dif.busy, 0);
        chk({tag, "_dma_address"}, dif.dma_address, 0);
        chk({tag, "_dev_index"}, dif.dev_index, 0);
        chk({tag, "_dma_write_data"}, dif.dma_write_data, 0);
        chk({tag, "_dma_mask"}, dif.dma_mask, 0);
    endtask

    initial begin
        int   ws0, d0, a0;
        bit   got;
        logic [15:0] ra, rl;
        reset_n = 1'b0;
        dif.begin_dma = 1'b0; dif.target_address = '0; dif.length = '0;
        rand_lat = 1'b0; rand_drop = 1'b0; drop_at_ack = -1; resp_acks = 0;
        n_checks = 0; n_fail = 0; pending_done = 0; done_cnt = 0;
        ack_cnt = 0; write_starts = 0; br_falls = 0;
        fill_buf();
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Three full bursts, then a short tail burst.
        fill_buf(); run_xfer(16'h000B, 16'd12, 1'b0);
        fill_buf(); run_xfer(16'h000B, 16'd6, 1'b0);

        // Zero length: no bus request, done exactly two cycles after begin.
        pending_done++;
        d0 = done_cnt;
        pulse_begin(16'h1234, 16'd0);
        @(negedge clk);
        chk("len0_done_c1", dif.dma_done, 0);
        chk("len0_br_c1", dif.br, 0);
        @(negedge clk);
        chk("len0_done_c2", dif.dma_done, 1);
        chk("len0_br_c2", dif.br, 0);
        @(negedge clk); #1;
        chk("len0_done_c3", dif.dma_done, 0);
        chk("len0_done_count", done_cnt - d0, 1);

        // Grant dropped during the second burst: one retry, three acks.
        fill_buf();
        ws0 = write_starts; a0 = ack_cnt;
        resp_acks = 0; drop_at_ack = 1;
        run_xfer(16'h000B, 16'd12, 1'b0);
        chk("retry_write_starts", write_starts - ws0, 4);
        chk("retry_ack_count", ack_cnt - a0, 3);
        drop_at_ack = -1;

        // Reset during the second burst aborts without a done pulse.
        fill_buf();
        a0 = ack_cnt;
        push_expect(16'h0040, 16'd12);
        pending_done++;
        pulse_begin(16'h0040, 16'd12);
        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk); #1;
            if (ack_cnt == a0 + 1 && dif.dma_write && !dif.mem_ack) got = 1'b1;
        end
        chk("second_burst_reached", got, 1);
        reset_n = 1'b0;
        #1;
        chk_all_zero("abort");
        exp_q.delete();
        pending_done = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort_no_done", dif.dma_done, 0);
        end
        #1 reset_n = 1'b1;
        fill_buf(); run_xfer(16'h000B, 16'd12, 1'b0);

        // Address wrap past 0xFFFF.
        fill_buf(); run_xfer(16'hFFFE, 16'd8, 1'b0);

        rand_lat = 1'b1; rand_drop = 1'b1;
        for (int t = 0; t < 25; t++) begin
            fill_buf();
            ra = ($urandom_range(0, 3) == 0) ? 16'hFFF0 + 16'($urandom_range(0, 15))
                                             : 16'($urandom);
            rl = 16'($urandom_range(0, 24));
            run_xfer(ra, rl, 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dma_controller.md
Name: dma_controller

Overview:
- Bus-master DMA engine that sits downstream of the CPU's DMA handshake.
- Consumes the CPU's begin_dma pulse, target_address and length, requests the memory bus with br and waits for bg.
- Copies `length` 16-bit words from the external device buffer into memory in 4-word (64-bit) bursts.
- Signals completion with a one-cycle interrupt pulse back to the CPU.

Parameters:
- WORD_SIZE, 16, width of addresses, length and data words
- BURST_WORDS, 4, words per memory burst; one 64-bit memory line
- LINE_WIDTH, 64, memory write-data width (WORD_SIZE*BURST_WORDS)

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- begin_dma  input  1  one-cycle start pulse from CPU
- target_address  input  WORD_SIZE  memory word address of first destination word
- length  input  WORD_SIZE  number of words to transfer
- bg  input  1  bus grant from CPU
- br  output  1  bus request to CPU
- dev_data  input  LINE_WIDTH  device buffer line selected by dev_index; word 0 in bits [15:0]
- dev_index  output  WORD_SIZE  current burst index into device buffer
- mem_ack  input  1  memory accepted current write (one-cycle pulse)
- dma_write  output  1  memory write strobe
- dma_address  output  WORD_SIZE  word address of current burst
- dma_write_data  output  LINE_WIDTH  burst data
- dma_mask  output  BURST_WORDS  per-word write enable
- dma_done  output  1  one-cycle completion interrupt to CPU
- busy  output  1  transfer in progress

Behaviour:
- Reset (asynchronous, reset_n=0): state IDLE; br, dma_write, dma_done, busy = 0; dma_address, dev_index, dma_write_data = 0; dma_mask = 0.
- Reset asserted mid-transfer aborts the transfer immediately. No dma_done is issued.
- IDLE: on begin_dma=1, latch target_address into addr, latch length into remaining, and clear dev_index.
  - If length==0: go to DONE.
  - Otherwise: go to REQ.
  - busy rises the cycle after begin_dma.
- REQ: br=1 registered, so it rises the cycle after begin_dma. Wait until bg=1, then go to WRITE.
- WRITE:
  - dma_write=1, dma_address=addr, dma_write_data=dev_data (registered on entry).
  - dma_mask = 4'b1111 if remaining>=4; otherwise the low `remaining` bits are set (1→0001, 2→0011, 3→0111).
  - Hold all outputs stable until mem_ack.
  - On mem_ack: addr += 4, remaining -= min(4, remaining), dev_index += 1, then go to NEXT.
- WRITE, bg dropped (bg=0 while mem_ack=0): deassert dma_write that cycle and return to REQ. The same burst is retried and counters are unchanged.
- mem_ack and bg falling in the same cycle: the ack wins and the burst counts as complete.
- NEXT:
  - remaining==0: br=0, go to DONE.
  - Otherwise: go to WRITE. br stays 1 and bg is rechecked there.
- DONE: dma_done=1 for exactly one cycle, busy=0 afterwards, br=0, return to IDLE.
- begin_dma outside IDLE is ignored.
- Address arithmetic is WORD_SIZE-bit and wraps modulo 2^16 (0xFFFE + 4 = 0x0002).
- dma_write is never asserted while bg=0 in the same cycle, other than the single drop cycle.

Optional Feature:
- Macro: DMA_CYCLE_STEAL_EN.
- Defined: in NEXT with remaining!=0, br drops for exactly one cycle before re-entering REQ, letting the CPU reclaim the bus between bursts. Each burst re-arbitrates.
- Undefined: br held continuously from REQ until the final burst completes (burst mode).

Decomposition:
- Shared package (dma_pkg) holds:
  - state encoding typedef: IDLE, REQ, WRITE, NEXT, DONE
  - WORD_SIZE, BURST_WORDS, LINE_WIDTH constants
  - mask-generation function (remaining → dma_mask)
- One natural sub-module, dma_burst_counter: holds addr, remaining and dev_index, with load and step controls, and produces last_burst and dma_mask.
- The FSM stays in dma_controller.

Test Plan:
- target_address=0x000B, length=12, bg one cycle after br, mem_ack 2 cycles after each dma_write → three bursts:
  - addresses 0x000B, 0x000F, 0x0013, each with dma_mask=1111
  - dev_index 0, 1, 2
  - then br=0, one dma_done pulse
- length=6 → two bursts: 0x000B mask 1111, then 0x000F mask 0011; dma_done once.
- length=0 → br never asserts; dma_done pulses exactly 2 cycles after begin_dma.
- bg dropped during the second WRITE before mem_ack → dma_write falls, br stays 1, the burst retries at the same address once bg returns; total 3 acks for length 12.
- reset_n low during the second burst → all outputs 0 immediately, no dma_done; a new begin_dma afterwards transfers normally.
- DMA_CYCLE_STEAL_EN defined, length=12 → br low for exactly one cycle between each burst (2 gaps); data and addresses identical to scenario 1.
